// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch queue between instruction memory and decode.
//
// Captures {PC, instruction} pairs from the fetch stage into a DEPTH-entry
// circular FIFO and presents the head entry to decode over valid/ready.
// A flush (branch/jump redirect) discards every queued entry in one cycle.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   When defined, an empty queue passes the incoming fetch straight through
//   to the outputs in the same cycle (zero-latency bypass).
//
// Parameters:
//   DEPTH   - number of entries (power of two, 2..16)
//   PC_W    - PC width
//   INSTR_W - instruction width
//
// Ports:
//   clk, reset_n           - rising-edge clock, asynchronous active-low reset
//   flush                  - drop all queued entries, block push/pop this cycle
//   in_valid/in_ready      - fetch-side handshake, in_pc/in_instr payload
//   out_valid/out_ready    - decode-side handshake, out_pc/out_instr payload
//   count                  - number of occupied entries
module fetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PC_W-1:0]    pc_d    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [INSTR_W-1:0] instr_d [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic empty, full, byp_vld, push, pop, wr_en, rd_en;

  // Handshake and output selection
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
`ifdef FETCH_BUF_BYPASS_EN
    byp_vld = empty && in_valid && !flush;
`else
    byp_vld = 1'b0;
`endif
    out_valid = !empty || byp_vld;
    // A full queue still accepts when the head leaves in the same cycle.
    in_ready  = !flush && (!full || (out_ready && out_valid));
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // A bypassed entry consumed immediately never touches storage or pointers.
    wr_en     = push && !(byp_vld && pop);
    rd_en     = pop && !byp_vld;
    out_pc    = byp_vld ? in_pc    : pc_q[rp_q];
    out_instr = byp_vld ? in_instr : instr_q[rp_q];
  end

  // Next-state
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      // Storage is left as-is; only pointers and occupancy are cleared.
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        pc_d[wp_q]    = in_pc;
        instr_d[wp_q] = in_instr;
        wp_d          = wp_q + PTR_ONE;
      end
      if (rd_en) begin
        rp_d = rp_q + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flush;
  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  ent_t q[$];   // reference queue contents, head at index 0

  fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queue model,
  // then advance the model by the handshake rules.
  task automatic step(input logic iv, input logic [PC_W-1:0] pc,
                      input logic [INSTR_W-1:0] ins, input logic ordy,
                      input logic fl, output logic acc);
    logic byp, ev, er, push, pop;
    ent_t e;
    @(negedge clk);
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    byp = (q.size() == 0) && iv && !fl;
`endif
    ev = (q.size() != 0) || byp;
    er = !fl && ((q.size() != DEPTH) || (ordy && ev));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready",  64'(in_ready),  64'(er));
    chk("count",     64'(count),     64'(q.size()));
    if (ev) begin
      if (q.size() != 0) begin
        chk("out_pc",    out_pc,           q[0].pc);
        chk("out_instr", 64'(out_instr),   64'(q[0].ins));
      end else begin
        chk("byp_pc",    out_pc,           pc);
        chk("byp_instr", 64'(out_instr),   64'(ins));
      end
    end
    push = iv && er;
    pop  = ev && ordy;
    acc  = push;
    if (fl) begin
      q.delete();
    end else if (!(byp && push && pop)) begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = pc; e.ins = ins;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    logic [PC_W-1:0]    pc_n;
    logic [INSTR_W-1:0] ins_n;
    logic iv, ordy, fl;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    out_pc,         64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);

    // Fill to full, refused push, drain, then wrap
    for (int i = 0; i < 4; i++) step(1'b1, 64'(4*i), 32'(32'hA0 + i), 1'b0, 1'b0, acc);
    step(1'b1, 64'd16, 32'hA4, 1'b0, 1'b0, acc);
    chk("full_refused", 64'(acc), 64'd0);
    chk("full_count",   64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);
    step(1'b1, 64'd16, 32'hB0, 1'b0, 1'b0, acc);
    step(1'b1, 64'd20, 32'hB1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);

    // Streaming
    for (int i = 0; i < 32; i++) step(1'b1, 64'(4*i), 32'(i), 1'b1, 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b1, 64'(200 + 4*i), 32'(i), 1'b0, 1'b0, acc);
    step(1'b1, 64'd100, 32'h64, 1'b1, 1'b0, acc);
    chk("full_pushpop_acc", 64'(acc),   64'd1);
    chk("full_pushpop_cnt", 64'(count), 64'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);

    // Flush with 3 entries queued and a push attempt
    for (int i = 0; i < 3; i++) step(1'b1, 64'(300 + 4*i), 32'(i), 1'b0, 1'b0, acc);
    step(1'b1, 64'hDEAD, 32'hDEAD, 1'b0, 1'b1, acc);
    chk("flush_refused", 64'(acc), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, acc);

    // Asynchronous reset between edges with 2 entries queued
    step(1'b1, 64'd400, 32'h1, 1'b0, 1'b0, acc);
    step(1'b1, 64'd404, 32'h2, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with a stalling decoder and occasional redirects
    pc_n  = 64'h1000;
    ins_n = $urandom;
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      step(iv, pc_n, ins_n, ordy, fl, acc);
      if (fl) begin
        pc_n  = {32'h0, $urandom} & ~64'h3;
        ins_n = $urandom;
      end else if (acc) begin
        pc_n  = pc_n + 64'd4;
        ins_n = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
